// File: rtl/game_ctrl_fsm.sv
// Snake game flow controller: mode select, ready/play/pause, death flash with
// multi-life accounting, game over and win. All outputs are registered.
module game_ctrl_fsm #(
  parameter int unsigned         LOCKOUT_CYC   = 150_000_000,
  parameter int unsigned         FLASH_CYC     = 50_000_000,
  parameter int unsigned         FLASH_TOGGLES = 4,
  parameter int unsigned         NUM_MODES     = 4,
  parameter int unsigned         MODE_W        = 2,
  parameter int unsigned         LIVES         = 3,
  parameter int unsigned         LIVES_W       = 2,
  parameter int unsigned         SCORE_W       = 12,
  parameter logic [SCORE_W-1:0]  WIN_BCD       = 12'h100
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [3:0]         i_key_n,
  input  logic               i_pause_key_n,
  input  logic               i_hit_wall,
  input  logic               i_hit_body,
  input  logic [SCORE_W-1:0] i_score_bcd,
  output logic [2:0]         o_game_status,
  output logic [MODE_W-1:0]  o_mode,
  output logic [LIVES_W-1:0] o_lives_left,
  output logic               o_snake_display,
  output logic               o_life_lost,
  output logic               o_game_won
);

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StReady = 3'd1,
    StPlay  = 3'd2,
    StPause = 3'd3,
    StDie   = 3'd4,
    StOver  = 3'd5,
    StWin   = 3'd6
  } state_e;

  localparam logic [31:0]        LockMax   = 32'(LOCKOUT_CYC);
  localparam logic [31:0]        FlashLast = 32'(FLASH_CYC - 1);
  localparam logic [31:0]        Half      = 32'(FLASH_CYC / FLASH_TOGGLES);
  localparam logic [MODE_W-1:0]  ModeLast  = MODE_W'(NUM_MODES - 1);
  localparam logic [LIVES_W-1:0] LivesInit = LIVES_W'(LIVES);

  state_e               r_state, w_state_d;
  logic [MODE_W-1:0]    r_mode, w_mode_d;
  logic [LIVES_W-1:0]   r_lives, w_lives_d;
  logic                 r_disp, w_disp_d;
  logic                 r_life_lost, w_life_lost_d;
  logic [31:0]          r_lock_cnt, w_lock_d;
  logic [31:0]          r_flash_cnt, w_flash_d;
  logic [3:0]           r_key_prev;
  logic                 r_pause_prev;

  logic [3:0]           w_key_ev;
  logic                 w_any_key;
  logic                 w_pause_ev;
  logic                 w_hit;
  logic [31:0]          w_flash_nxt;

  // Press events: released on the previous sample, pressed on this one.
  assign w_key_ev    = r_key_prev & ~i_key_n;
  assign w_any_key   = |w_key_ev;
  assign w_pause_ev  = r_pause_prev & ~i_pause_key_n;
  assign w_hit       = i_hit_wall | i_hit_body;
  assign w_flash_nxt = r_flash_cnt + 32'd1;

  always_comb begin
    w_state_d     = r_state;
    w_mode_d      = r_mode;
    w_lives_d     = r_lives;
    w_disp_d      = r_disp;
    w_life_lost_d = 1'b0;
    w_lock_d      = r_lock_cnt;
    w_flash_d     = r_flash_cnt;

    unique case (r_state)
      StIdle: begin
        if (r_lock_cnt < LockMax) begin
          w_lock_d = r_lock_cnt + 32'd1;
        end else if (w_key_ev[3]) begin
          w_state_d = StReady;
          w_lives_d = LivesInit;
        end else if (w_key_ev[0] && !w_key_ev[1]) begin
          w_mode_d = (r_mode == ModeLast) ? '0 : r_mode + MODE_W'(1);
        end else if (w_key_ev[1] && !w_key_ev[0]) begin
          w_mode_d = (r_mode == '0) ? ModeLast : r_mode - MODE_W'(1);
        end
      end
      StReady: begin
        if (w_any_key) w_state_d = StPlay;
      end
      StPlay: begin
        if (w_hit) begin
          w_state_d     = StDie;
          w_lives_d     = (r_lives == '0) ? '0 : r_lives - LIVES_W'(1);
          w_life_lost_d = 1'b1;
          w_flash_d     = '0;
          w_disp_d      = 1'b1;
        end else if (i_score_bcd >= WIN_BCD) begin
          w_state_d = StWin;
        end else if (w_pause_ev) begin
          w_state_d = StPause;
        end
      end
      StPause: begin
        if (w_pause_ev) w_state_d = StPlay;
      end
      StDie: begin
        if (r_flash_cnt == FlashLast) begin
          w_flash_d = '0;
          w_disp_d  = 1'b1;
          w_state_d = (r_lives != '0) ? StReady : StOver;
        end else begin
          w_flash_d = w_flash_nxt;
          // Toggle as the counter reaches each phase boundary k*Half.
          if ((w_flash_nxt % Half) == 32'd0) w_disp_d = ~r_disp;
        end
      end
      StOver: begin
        if (w_any_key) begin
          w_state_d = StIdle;
          w_lock_d  = '0;
        end
      end
      StWin: begin
        w_disp_d = 1'b1;
        if (w_any_key) begin
          w_state_d = StIdle;
          w_lock_d  = '0;
        end
      end
      default: begin
        w_state_d = StIdle;
        w_lock_d  = '0;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= StIdle;
      r_mode       <= '0;
      r_lives      <= LivesInit;
      r_disp       <= 1'b1;
      r_life_lost  <= 1'b0;
      r_lock_cnt   <= '0;
      r_flash_cnt  <= '0;
      r_key_prev   <= '1;
      r_pause_prev <= 1'b1;
    end else begin
      r_state      <= w_state_d;
      r_mode       <= w_mode_d;
      r_lives      <= w_lives_d;
      r_disp       <= w_disp_d;
      r_life_lost  <= w_life_lost_d;
      r_lock_cnt   <= w_lock_d;
      r_flash_cnt  <= w_flash_d;
      r_key_prev   <= i_key_n;
      r_pause_prev <= i_pause_key_n;
    end
  end

  assign o_game_status   = r_state;
  assign o_mode          = r_mode;
  assign o_lives_left    = r_lives;
  assign o_snake_display = r_disp;
  assign o_life_lost     = r_life_lost;
  assign o_game_won      = (r_state == StWin);

endmodule

// File: tb/tb_game_ctrl_fsm.sv
// Directed bench for game_ctrl_fsm: the driver queues hand-computed snapshots,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_game_ctrl_fsm;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  key_n;
  logic        pause_n;
  logic        hit_wall;
  logic        hit_body;
  logic [11:0] score;
  logic [2:0]  st;
  logic [1:0]  mode;
  logic [1:0]  lives;
  logic        disp;
  logic        ll;
  logic        won;

  game_ctrl_fsm #(
    .LOCKOUT_CYC  (10),
    .FLASH_CYC    (8),
    .FLASH_TOGGLES(4),
    .NUM_MODES    (4),
    .MODE_W       (2),
    .LIVES        (2),
    .LIVES_W      (2),
    .SCORE_W      (12),
    .WIN_BCD      (12'h100)
  ) u_dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_key_n        (key_n),
    .i_pause_key_n  (pause_n),
    .i_hit_wall     (hit_wall),
    .i_hit_body     (hit_body),
    .i_score_bcd    (score),
    .o_game_status  (st),
    .o_mode         (mode),
    .o_lives_left   (lives),
    .o_snake_display(disp),
    .o_life_lost    (ll),
    .o_game_won     (won)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    string      name;
    logic [9:0] v;
  } exp_t;

  exp_t q[$];
  int   edge_cnt = 0;
  int   n_chk    = 0;
  int   n_fail   = 0;
  logic done     = 1'b0;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_st(input string nm, input logic [2:0] s, input logic [1:0] m,
                           input logic [1:0] l, input logic d, input logic p, input logic w);
    exp_t e;
    e.cyc  = edge_cnt;
    e.name = nm;
    e.v    = {s, m, l, d, p, w};
    q.push_back(e);
  endtask

  // k = 0..3 direction keys, 4 = pause key; held low across one edge.
  task automatic press(input int k);
    if (k == 4) pause_n = 1'b0;
    else        key_n[k] = 1'b0;
    tick();
  endtask

  task automatic release_keys();
    key_n   = 4'hF;
    pause_n = 1'b1;
    tick();
  endtask

  // Monitor: compares every queued snapshot on the negedge after its edge.
  always @(negedge clk) begin
    exp_t       e;
    logic [9:0] act;
    act = {st, mode, lives, disp, ll, won};
    while (q.size() > 0 && q[0].cyc <= edge_cnt) begin
      e = q.pop_front();
      n_chk++;
      if (e.cyc != edge_cnt) begin
        n_fail++;
        $display("FAIL %s: snapshot for edge %0d missed, now edge %0d", e.name, e.cyc, edge_cnt);
      end else if (act !== e.v) begin
        n_fail++;
        $display("FAIL %s: got st=%0d mode=%0d lives=%0d disp=%0b ll=%0b won=%0b, want st=%0d mode=%0d lives=%0d disp=%0b ll=%0b won=%0b",
                 e.name, act[9:7], act[6:5], act[4:3], act[2], act[1], act[0],
                 e.v[9:7], e.v[6:5], e.v[4:3], e.v[2], e.v[1], e.v[0]);
      end
    end
    if (done) begin
      n_chk++;
      if (q.size() != 0) begin
        n_fail++;
        $display("FAIL queue_drain: %0d snapshots left, want 0", q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish within time limit");
    $fatal(1, "timeout");
  end

  logic [1:0] wrap_seq  [4] = '{2'd2, 2'd3, 2'd0, 2'd1};
  logic       flash_seq [8] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};

  initial begin
    rst = 1'b1; key_n = 4'hF; pause_n = 1'b1;
    hit_wall = 1'b0; hit_body = 1'b0; score = 12'h000;
    tick(); tick();
    expect_st("reset", 3'd0, 2'd0, 2'd2, 1'b1, 1'b0, 1'b0);
    rst = 1'b0;

    // Lockout and mode selection
    repeat (4) tick();
    press(0); expect_st("lockout_right", 3'd0, 2'd0, 2'd2, 1'b1, 1'b0, 1'b0); release_keys();
    repeat (4) tick();
    press(0); expect_st("right_after_lockout", 3'd0, 2'd1, 2'd2, 1'b1, 1'b0, 1'b0);
    release_keys();
    for (int i = 0; i < 4; i++) begin
      press(0); expect_st("right_wrap", 3'd0, wrap_seq[i], 2'd2, 1'b1, 1'b0, 1'b0);
      release_keys();
    end
    key_n[0] = 1'b0; tick();
    expect_st("hold_right_first", 3'd0, 2'd2, 2'd2, 1'b1, 1'b0, 1'b0);
    repeat (19) tick();
    expect_st("hold_right_end", 3'd0, 2'd2, 2'd2, 1'b1, 1'b0, 1'b0);
    release_keys();
    key_n = 4'b1100; tick();
    expect_st("left_right_same", 3'd0, 2'd2, 2'd2, 1'b1, 1'b0, 1'b0); release_keys();
    press(1); expect_st("left_2_1", 3'd0, 2'd1, 2'd2, 1'b1, 1'b0, 1'b0); release_keys();
    press(1); expect_st("left_1_0", 3'd0, 2'd0, 2'd2, 1'b1, 1'b0, 1'b0); release_keys();
    press(1); expect_st("left_wrap", 3'd0, 2'd3, 2'd2, 1'b1, 1'b0, 1'b0); release_keys();

    // Start, pause, resume
    press(3); expect_st("up_ready", 3'd1, 2'd3, 2'd2, 1'b1, 1'b0, 1'b0); release_keys();
    press(4); expect_st("ready_ignores_pause", 3'd1, 2'd3, 2'd2, 1'b1, 1'b0, 1'b0);
    release_keys();
    press(2); expect_st("down_play", 3'd2, 2'd3, 2'd2, 1'b1, 1'b0, 1'b0); release_keys();
    press(4); expect_st("pause", 3'd3, 2'd3, 2'd2, 1'b1, 1'b0, 1'b0); release_keys();
    hit_wall = 1'b1; tick(); tick();
    expect_st("pause_ignores_wall", 3'd3, 2'd3, 2'd2, 1'b1, 1'b0, 1'b0);
    hit_wall = 1'b0;
    press(0); expect_st("pause_ignores_dir", 3'd3, 2'd3, 2'd2, 1'b1, 1'b0, 1'b0); release_keys();
    press(4); expect_st("resume", 3'd2, 2'd3, 2'd2, 1'b1, 1'b0, 1'b0); release_keys();

    // First death with flash sequence
    hit_body = 1'b1; tick(); hit_body = 1'b0;
    expect_st("die_first", 3'd4, 2'd3, 2'd1, flash_seq[0], 1'b1, 1'b0);
    for (int i = 1; i < 8; i++) begin
      tick(); expect_st("flash", 3'd4, 2'd3, 2'd1, flash_seq[i], 1'b0, 1'b0);
    end
    tick(); expect_st("ready_after_die", 3'd1, 2'd3, 2'd1, 1'b1, 1'b0, 1'b0);
    press(2); expect_st("play_life2", 3'd2, 2'd3, 2'd1, 1'b1, 1'b0, 1'b0); release_keys();

    // Last life
    hit_wall = 1'b1; tick(); hit_wall = 1'b0;
    expect_st("die_last", 3'd4, 2'd3, 2'd0, 1'b1, 1'b1, 1'b0);
    repeat (7) tick();
    tick(); expect_st("over", 3'd5, 2'd3, 2'd0, 1'b1, 1'b0, 1'b0);
    press(1); expect_st("over_to_idle", 3'd0, 2'd3, 2'd0, 1'b1, 1'b0, 1'b0); release_keys();
    repeat (10) tick();
    key_n = 4'b0110; tick();
    expect_st("up_beats_right", 3'd1, 2'd3, 2'd2, 1'b1, 1'b0, 1'b0); release_keys();
    press(2); expect_st("play_game2", 3'd2, 2'd3, 2'd2, 1'b1, 1'b0, 1'b0); release_keys();

    // Win threshold and collision priority
    score = 12'h099; tick();
    expect_st("score_099", 3'd2, 2'd3, 2'd2, 1'b1, 1'b0, 1'b0);
    score = 12'h100; hit_wall = 1'b1; tick(); hit_wall = 1'b0; score = 12'h000;
    expect_st("collision_over_win", 3'd4, 2'd3, 2'd1, 1'b1, 1'b1, 1'b0);
    repeat (7) tick();
    tick(); expect_st("ready_game2", 3'd1, 2'd3, 2'd1, 1'b1, 1'b0, 1'b0);
    press(2); expect_st("play_game2_life2", 3'd2, 2'd3, 2'd1, 1'b1, 1'b0, 1'b0); release_keys();
    score = 12'h100; tick(); score = 12'h000;
    expect_st("win", 3'd6, 2'd3, 2'd1, 1'b1, 1'b0, 1'b1);
    press(0); expect_st("win_to_idle", 3'd0, 2'd3, 2'd1, 1'b1, 1'b0, 1'b0); release_keys();

    // Reset in the middle of the flash
    repeat (10) tick();
    press(1); expect_st("left_to_2", 3'd0, 2'd2, 2'd1, 1'b1, 1'b0, 1'b0); release_keys();
    press(3); expect_st("ready_game3", 3'd1, 2'd2, 2'd2, 1'b1, 1'b0, 1'b0); release_keys();
    press(2); expect_st("play_game3", 3'd2, 2'd2, 2'd2, 1'b1, 1'b0, 1'b0); release_keys();
    hit_body = 1'b1; tick(); hit_body = 1'b0;
    expect_st("die_game3", 3'd4, 2'd2, 2'd1, 1'b1, 1'b1, 1'b0);
    repeat (3) tick();
    expect_st("die_cnt3", 3'd4, 2'd2, 2'd1, 1'b0, 1'b0, 1'b0);
    rst = 1'b1; tick(); rst = 1'b0;
    expect_st("reset_mid_die", 3'd0, 2'd0, 2'd2, 1'b1, 1'b0, 1'b0);

    repeat (3) tick();
    done = 1'b1;
  end

endmodule
